// File: rtl/hazard_sequencer_if.sv
// Stage-control bundle between the 5-stage core datapath and its hazard sequencer.
// The core (master) drives per-stage control bits; the sequencer (slave) drives write enables, bubbles and halt.
interface hazard_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_is_ecall;
  logic [4:0]       ex_rd;
  logic             ex_wb_enable;
  logic             ex_mem_read;
  logic [4:0]       mem_rd;
  logic             mem_wb_enable;
  logic             x17_is_10;
  logic             dmem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic             is_halted;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       seq_state;

  // No valid/ready pairs here: every signal is a level that is sampled on
  // every rising clock edge; outputs are a function of the current state and
  // the same-cycle inputs.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall,
           ex_rd, ex_wb_enable, ex_mem_read, mem_rd, mem_wb_enable,
           x17_is_10, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
           is_halted, stall_count, seq_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall,
           ex_rd, ex_wb_enable, ex_mem_read, mem_rd, mem_wb_enable,
           x17_is_10, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
           is_halted, stall_count, seq_state
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard sequencer for the 5-stage RV32I core: load-use and ECALL/x17 stalls,
// data-memory freeze, and the ECALL squash/drain/halt sequence.
module hazard_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input logic               clk,
  input logic               reset_n,
  hazard_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;
  logic             load_use, ecall_haz, stall;
  logic             pc_w, ifid_w, flush, bubble, freeze;

  always_comb begin
    load_use  = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                 (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    ecall_haz = bus.id_is_ecall &&
                ((bus.ex_wb_enable  && (bus.ex_rd  == 5'd17)) ||
                 (bus.mem_wb_enable && (bus.mem_rd == 5'd17)));
    stall     = load_use || ecall_haz;
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_inc = 1'b0;
    pc_w    = 1'b0;
    ifid_w  = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    freeze  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.dmem_busy) begin
          freeze = 1'b1;
        end else if (stall) begin
          bubble  = 1'b1;
          cnt_inc = 1'b1;
        end else if (bus.id_is_ecall && bus.x17_is_10) begin
          // Halting ECALL moves on to EX; whatever was fetched behind it is squashed.
          flush   = 1'b1;
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          pc_w   = 1'b1;
          ifid_w = 1'b1;
        end
      end
      DRAIN: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (bus.dmem_busy) begin
          freeze = 1'b1;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      HALTED: begin
        flush  = 1'b1;
        bubble = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // While reset is held the fetch side is parked on NOPs regardless of inputs.
  assign bus.pc_write    = reset_n & pc_w;
  assign bus.ifid_write  = reset_n & ifid_w;
  assign bus.ifid_flush  = ~reset_n | flush;
  assign bus.idex_bubble = ~reset_n | bubble;
  assign bus.pipe_freeze = reset_n & freeze;
  assign bus.is_halted   = reset_n & (state_q == HALTED);
  assign bus.stall_count = cnt_q;
  assign bus.seq_state   = state_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed plus randomized bench for hazard_sequencer with a cycle-level reference model.
module tb_hazard_sequencer;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

  hazard_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: mode 0 running, 1 draining, 2 halted
  int m_mode, m_left, m_cnt;
  int n_mode, n_left, n_cnt;
  logic obs_halted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_is_ecall = 0; bus.ex_rd = 0; bus.ex_wb_enable = 0; bus.ex_mem_read = 0;
    bus.mem_rd = 0; bus.mem_wb_enable = 0; bus.x17_is_10 = 0; bus.dmem_busy = 0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd17;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    logic e_pc, e_ifw, e_fl, e_bub, e_frz, e_halt, lu, eh;
    #1;
    lu = bus.ex_mem_read && bus.ex_rd != 0 &&
         ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    eh = bus.id_is_ecall && ((bus.ex_wb_enable && bus.ex_rd == 17) || (bus.mem_wb_enable && bus.mem_rd == 17));
    {e_pc, e_ifw, e_fl, e_bub, e_frz} = 5'b00000;
    e_halt = (m_mode == 2);
    n_mode = m_mode; n_left = m_left; n_cnt = m_cnt;
    if (m_mode == 0) begin
      if (bus.dmem_busy) e_frz = 1;
      else if (lu || eh) begin
        e_bub = 1;
        n_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end else if (bus.id_is_ecall && bus.x17_is_10) begin
        e_fl = 1; n_mode = 1; n_left = DRAIN_CYCLES;
      end else begin
        e_pc = 1; e_ifw = 1;
      end
    end else begin
      e_fl = 1; e_bub = 1;
      if (m_mode == 1) begin
        e_frz = bus.dmem_busy;
        if (!bus.dmem_busy) begin
          n_left = m_left - 1;
          if (n_left == 0) n_mode = 2;
        end
      end
    end
    check("pc_write",    bus.pc_write,    e_pc);
    check("ifid_write",  bus.ifid_write,  e_ifw);
    check("ifid_flush",  bus.ifid_flush,  e_fl);
    check("idex_bubble", bus.idex_bubble, e_bub);
    check("pipe_freeze", bus.pipe_freeze, e_frz);
    check("is_halted",   bus.is_halted,   e_halt);
    check("stall_count", bus.stall_count, m_cnt);
    obs_halted = bus.is_halted;
    @(posedge clk);
    m_mode = n_mode; m_left = n_left; m_cnt = n_cnt;
    @(negedge clk);
  endtask

  // Assert reset mid-cycle and check the asynchronous effect before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    check({tag, "_pc_write"},    bus.pc_write,    1'b0);
    check({tag, "_ifid_write"},  bus.ifid_write,  1'b0);
    check({tag, "_ifid_flush"},  bus.ifid_flush,  1'b1);
    check({tag, "_idex_bubble"}, bus.idex_bubble, 1'b1);
    check({tag, "_pipe_freeze"}, bus.pipe_freeze, 1'b0);
    check({tag, "_is_halted"},   bus.is_halted,   1'b0);
    check({tag, "_stall_count"}, bus.stall_count, 0);
    m_mode = 0; m_left = 0; m_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic halt_latency(input string tag, input int busy_from, input int busy_len, input int exp_k);
    int k;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      bus.dmem_busy = (i >= busy_from) && (i < busy_from + busy_len);
      cycle();
      if (obs_halted) begin
        k = i;
        break;
      end
    end
    bus.dmem_busy = 0;
    check(tag, k, exp_k);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_mode = 0; m_left = 0; m_cnt = 0;
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    bus.id_is_ecall = 1; bus.x17_is_10 = 1; bus.dmem_busy = 1;
    #1;
    check("rst_pc_write",    bus.pc_write,    1'b0);
    check("rst_ifid_flush",  bus.ifid_flush,  1'b1);
    check("rst_idex_bubble", bus.idex_bubble, 1'b1);
    check("rst_pipe_freeze", bus.pipe_freeze, 1'b0);
    check("rst_is_halted",   bus.is_halted,   1'b0);
    check("rst_stall_count", bus.stall_count, 0);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    cycle();

    // load-use on x5: one stall cycle
    bus.ex_rd = 5; bus.ex_mem_read = 1; bus.ex_wb_enable = 1; bus.id_rs1 = 5; bus.id_use_rs1 = 1;
    cycle();
    check("lu_count_after", bus.stall_count, 1);
    idle();
    cycle();

    // load to x0 never stalls
    bus.ex_rd = 0; bus.ex_mem_read = 1; bus.id_rs1 = 0; bus.id_use_rs1 = 1;
    cycle(); cycle();
    idle();

    // ECALL behind x17 writers in EX then MEM, then halting ECALL
    bus.id_is_ecall = 1; bus.x17_is_10 = 1;
    bus.ex_rd = 17; bus.ex_wb_enable = 1;
    cycle();
    bus.ex_wb_enable = 0; bus.mem_rd = 17; bus.mem_wb_enable = 1;
    cycle();
    bus.mem_wb_enable = 0;
    cycle();
    idle();
    halt_latency("halt_latency", 99, 0, DRAIN_CYCLES + 1);
    cycle();
    async_reset("rst_halted");
    cycle();

    // ECALL with x17 != 10 is a NOP
    bus.id_is_ecall = 1; bus.x17_is_10 = 0;
    cycle(); cycle();
    idle();
    cycle();

    // dmem_busy for 4 cycles inside DRAIN delays halt by 4
    bus.id_is_ecall = 1; bus.x17_is_10 = 1;
    cycle();
    idle();
    halt_latency("halt_latency_busy", 2, 4, DRAIN_CYCLES + 1 + 4);
    async_reset("rst_halted2");

    // reset in the middle of DRAIN
    bus.id_is_ecall = 1; bus.x17_is_10 = 1;
    cycle();
    idle();
    cycle();
    async_reset("rst_drain");
    cycle();

    // saturation of stall_count
    bus.ex_rd = 9; bus.ex_mem_read = 1; bus.id_rs2 = 9; bus.id_use_rs2 = 1;
    for (int i = 0; i < CNT_MAX + 5; i++) cycle();
    check("stall_count_sat", bus.stall_count, CNT_MAX);
    idle();
    async_reset("rst_sat");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.id_rs1 = pick_reg(); bus.id_rs2 = pick_reg();
      bus.id_use_rs1 = 1'($urandom_range(0, 1)); bus.id_use_rs2 = 1'($urandom_range(0, 1));
      bus.id_is_ecall = ($urandom_range(0, 9) < 2);
      bus.ex_rd = pick_reg(); bus.ex_wb_enable = 1'($urandom_range(0, 1));
      bus.ex_mem_read = ($urandom_range(0, 9) < 4);
      bus.mem_rd = pick_reg(); bus.mem_wb_enable = 1'($urandom_range(0, 1));
      bus.x17_is_10 = ($urandom_range(0, 9) < 3);
      bus.dmem_busy = ($urandom_range(0, 9) < 2);
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        async_reset("rst_rand");
      else
        cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout compared=%0d", n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
